peripheral_noc_packet_arbiter: RTL
==================================

Name: peripheral_noc_packet_arbiter

Overview:
Packet-level N:1 arbiter that merges CHANNELS flit streams onto one NoC link; it is the counterpart of the class-based demux on the receive side.
- A channel wins by round-robin on its head flit.
- The winner keeps the link until its last flit has been transferred, so packets are never interleaved.
- The output is registered: one pipeline stage between the arbiter and the link.

Parameters:
- FLIT_WIDTH, 32, flit width in bits.
- CHANNELS, 2, number of input channels (1..8).
- PRIO_CLASSES, 8'h00, bit c set means packet class c is high-priority. Only used when the optional feature is compiled in.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- in_flit  in  [CHANNELS-1:0][FLIT_WIDTH-1:0]  per-channel flit.
- in_last  in  [CHANNELS-1:0]  last flit of packet.
- in_valid  in  [CHANNELS-1:0]  flit valid.
- in_ready  out  [CHANNELS-1:0]  flit accepted when valid&ready.
- out_flit  out  FLIT_WIDTH  registered output flit.
- out_last  out  1  registered last.
- out_valid  out  1  registered valid.
- out_ready  in  1  downstream ready.
- owner  out  [CHANNELS-1:0]  one-hot channel currently holding the link; 0 when idle.

Interface (already decided): reset rst, synchronous, active-high; clock clk.

Behaviour:
- Reset values: out_valid=0, out_last=0, out_flit=0, owner=0, state=IDLE, prev_grant=one-hot bit CHANNELS-1 (so channel 0 wins first).
- Output slot readiness: slot_ready = ~out_valid | out_ready.
- Slot load: when a flit is accepted, the slot loads it on the same edge.
- Slot drain: when out_valid&out_ready and nothing is accepted, out_valid clears.
- Throughput and latency: one flit per cycle sustained; one cycle from input acceptance to out_valid.
- IDLE state:
  - grant = round-robin over in_valid, starting at the channel after prev_grant.
  - in_ready = grant & {CHANNELS{slot_ready}}.
  - The grant is combinational and committed only on acceptance. Senders hold valid stable, so only a new, higher-ranked request may change the grant before acceptance.
- IDLE transitions:
  - Accepted flit with last=0: go to BUSY, owner=grant.
  - Accepted flit with last=1 (single-flit packet): stay in IDLE, prev_grant=grant.
- BUSY state:
  - in_ready = owner & {CHANNELS{slot_ready}}.
  - Other channels are stalled even if valid.
  - An owner valid gap (bubble) keeps the lock.
  - Accepted last: go to IDLE, prev_grant=owner, owner=0.
- Back-to-back packets: the next packet may be granted in the cycle after the last flit is accepted; no idle cycle is forced on the output.
- No valid inputs: in_ready=0 and the state is unchanged.
- CHANNELS=1: the arbiter degenerates to a registered pass-through with a packet-lock state machine.
- Reset mid-packet: owner, state and output slot are cleared and the in-flight flit is dropped. Upstream shares the same reset.
- No combinational path from out_ready to out_valid. in_ready depends combinationally on out_ready and in_valid.

Optional Feature:
- Macro: PERIPHERAL_NOC_ARB_PRIO_EN.
- Defined:
  - In IDLE, the class of each valid head flit (bits 26:24) is looked up in PRIO_CLASSES.
  - If any high-priority head is valid, round-robin runs only among those channels; otherwise among all valid channels.
  - prev_grant updates identically in both cases.
  - No preemption while BUSY.
- Undefined: PRIO_CLASSES is ignored; pure round-robin.

Decomposition:
- Package peripheral_noc_pkg holds:
  - CLASS_MSB=26, CLASS_LSB=24.
  - typedef enum {IDLE, BUSY} arb_state_t.
- Sub-module peripheral_noc_rr_arbiter (combinational, parameter N):
  - Inputs: req[N], prev[N] one-hot.
  - Output: grant[N] one-hot, or zero when there is no request.
  - Implementation: double-width mask-and-priority.

Test Plan:
- Reset, then ch0 and ch1 each send one 3-flit packet simultaneously, out_ready=1 → ch0's 3 flits appear first, then ch1's; out_last on flits 3 and 6; owner goes 01→00→10→00 around packet boundaries.
- ch1 packet in progress and ch0 asserts valid mid-packet → ch0 in_ready=0 until ch1 last accepted; ch0 granted the next cycle; no flit interleaving.
- Continuous single-flit packets on all 4 channels (CHANNELS=4) → grant order 0,1,2,3,0,… with one output flit per cycle.
- Backpressure: toggle out_ready 1,0,0,1 during a 4-flit packet → no flit lost or duplicated; out_flit stable while out_valid&~out_ready.
- Owner bubble: ch0 drops valid for 2 cycles mid-packet while ch1 is valid → ch1 never granted until ch0 last.
- Assert rst during flit 2 of 4 → next cycle out_valid=0 and owner=0; after release, channel 0 wins first.
- Priority, with PERIPHERAL_NOC_ARB_PRIO_EN and PRIO_CLASSES=8'h04: ch0 head class 0 and ch1 head class 2, both valid → ch1 granted first. Without the macro → ch0 granted first.

Source files
------------

// File: rtl/peripheral_noc_pkg.sv
// peripheral_noc_pkg: shared constants and types for the NoC packet arbiter.
package peripheral_noc_pkg;
   localparam int CLASS_MSB = 26;
   localparam int CLASS_LSB = 24;
   typedef enum logic {IDLE, BUSY} arb_state_t;
endpackage

// File: rtl/peripheral_noc_rr_arbiter.sv
// peripheral_noc_rr_arbiter: combinational round-robin arbiter, search starts after the previous grant.
module peripheral_noc_rr_arbiter #(
   parameter int N = 2
) (
   input  logic [N-1:0] req,
   input  logic [N-1:0] prev,
   output logic [N-1:0] grant
);
   logic [2*N-1:0] dbl, base, hit;
   // Doubling the request vector lets the subtract trick wrap around past channel N-1.
   assign dbl   = {req, req};
   assign base  = {{N{1'b0}}, prev} << 1;
   assign hit   = dbl & ~(dbl - base);
   assign grant = hit[N-1:0] | hit[2*N-1:N];
endmodule

// File: rtl/peripheral_noc_packet_arbiter.sv
// peripheral_noc_packet_arbiter: packet-locked round-robin N:1 flit merger with a registered output slot.
// Optional class-priority arbitration is compiled in with PERIPHERAL_NOC_ARB_PRIO_EN.
module peripheral_noc_packet_arbiter
   import peripheral_noc_pkg::*;
#(
   parameter int        FLIT_WIDTH   = 32,
   parameter int        CHANNELS     = 2,
   parameter logic [7:0] PRIO_CLASSES = 8'h00
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  in_flit,
   input  logic [CHANNELS-1:0]                  in_last,
   input  logic [CHANNELS-1:0]                  in_valid,
   output logic [CHANNELS-1:0]                  in_ready,
   output logic [FLIT_WIDTH-1:0]                out_flit,
   output logic                                 out_last,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [CHANNELS-1:0]                  owner
);
   arb_state_t            state_q;
   logic [CHANNELS-1:0]   owner_q, prev_q, req, grant, sel;
   logic [FLIT_WIDTH-1:0] out_flit_q, flit_d;
   logic                  out_valid_q, out_last_q, last_d, slot_ready, accept;
`ifdef PERIPHERAL_NOC_ARB_PRIO_EN
   logic [CHANNELS-1:0]   hi;
   always_comb begin
      hi = '0;
      for (int c = 0; c < CHANNELS; c++)
         hi[c] = in_valid[c] & PRIO_CLASSES[in_flit[c][CLASS_MSB:CLASS_LSB]];
   end
   assign req = |hi ? hi : in_valid;
`else
   assign req = in_valid;
`endif
   peripheral_noc_rr_arbiter #(.N(CHANNELS)) u_rr (
      .req  (req),
      .prev (prev_q),
      .grant(grant)
   );
   assign slot_ready = ~out_valid_q | out_ready;
   assign sel        = (state_q == BUSY) ? owner_q : grant;
   assign in_ready   = sel & {CHANNELS{slot_ready}};
   assign accept     = |(in_ready & in_valid);
   always_comb begin
      flit_d = '0;
      last_d = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         flit_d = flit_d | (in_flit[c] & {FLIT_WIDTH{sel[c]}});
         last_d = last_d | (in_last[c] & sel[c]);
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q                <= IDLE;
         owner_q                <= '0;
         prev_q                 <= '0;
         prev_q[CHANNELS-1]     <= 1'b1;
         out_valid_q            <= 1'b0;
         out_last_q             <= 1'b0;
         out_flit_q             <= '0;
      end else begin
         if (accept) begin
            out_flit_q  <= flit_d;
            out_last_q  <= last_d;
            out_valid_q <= 1'b1;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
         // The lock is taken on a non-last head and released on the accepted last flit.
         if (accept && last_d) begin
            state_q <= IDLE;
            owner_q <= '0;
            prev_q  <= sel;
         end else if (accept) begin
            state_q <= BUSY;
            owner_q <= sel;
         end
      end
   end
   assign out_flit  = out_flit_q;
   assign out_last  = out_last_q;
   assign out_valid = out_valid_q;
   assign owner     = owner_q;
endmodule
